prbs4_checker: RTL

- Receive-side checker for the 4-bit PRBS word stream (polynomial x^4 + x + 1) produced by the team's LFSR generator.
- Self-synchronises to the incoming sequence, declares lock, and then counts word errors and locked beats for BER measurement.
- Sits at the far end of a loopback or link-test path, driven by the generator's word output plus a valid strobe.

---
 rtl/prbs_pkg.sv | 17 +
 rtl/sat_counter.sv | 32 +++
 rtl/prbs4_checker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS4 state encoding, taps and next-word function
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Feedback taps for x^4 + x + 1: new MSB is w[1] ^ w[0]
    localparam logic [3:0] PRBS4_TAPS = 4'b0011;

    function automatic logic [3:0] prbs4_next(input logic [3:0] w);
        return {^(w & PRBS4_TAPS), w[3:1]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_base;

    // Clear applies before the increment, so clr with inc leaves the count at 1
    always_comb begin
        w_base = clr ? '0 : r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (w_base != {W{1'b1}})) begin
            r_q <= w_base + W'(1);
        end else begin
            r_q <= w_base;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/prbs4_checker.sv
// rtl/prbs4_checker.sv - self-synchronising PRBS4 word checker with error/beat counters
module prbs4_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] beat_count,
    output logic             lost_lock
);

    localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
    localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pred;
    logic [3:0] w_pred_nxt;
    logic [3:0] r_match_cnt;
    logic [3:0] w_match_nxt;
    logic [3:0] r_miss_cnt;
    logic [3:0] w_miss_nxt;
    logic       r_locked;
    logic       r_err_pulse;
    logic       r_lost_lock;
    logic       w_mismatch;
    logic       w_beat;
    logic       w_err;
    logic       w_lose;

    assign w_mismatch = (in_data != r_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_pred      <= 4'd0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (in_data != 4'd0) begin
                        w_pred_nxt  = prbs4_next(in_data);
                        w_match_nxt = 4'd0;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (!w_mismatch) begin
                        w_pred_nxt  = prbs4_next(in_data);
                        w_match_nxt = r_match_cnt + 4'd1;
                        if (r_match_cnt + 4'd1 == LOCK_T) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = 4'd0;
                        end
                    end else if (in_data != 4'd0) begin
                        w_pred_nxt  = prbs4_next(in_data);
                        w_match_nxt = 4'd0;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-running predictor: a corrupted word never reseeds it
                    w_pred_nxt = prbs4_next(r_pred);
                    if (!w_mismatch) begin
                        w_miss_nxt = 4'd0;
                    end else if (r_miss_cnt + 4'd1 == LOSS_T) begin
                        w_state_nxt = HUNT;
                        w_miss_nxt  = 4'd0;
                    end else begin
                        w_miss_nxt = r_miss_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        w_beat = in_valid && (r_state == LOCKED);
        w_err  = w_beat && w_mismatch;
        w_lose = w_err && (r_miss_cnt + 4'd1 == LOSS_T);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_lost_lock <= 1'b0;
        end else begin
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
            if (w_lose) begin
                r_lost_lock <= 1'b1;
            end else if (clr_cnt) begin
                r_lost_lock <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_err),
        .q   (err_count)
    );

    sat_counter #(.W(CNT_W)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_beat),
        .q   (beat_count)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign lost_lock = r_lost_lock;

endmodule
